page_walker: RTL and testbench

- Two-level (Sv32-style) hardware page-table walker that sits directly upstream of the MMU tag RAM.
- Accepts a translation miss (VPN) and reads one or two PTEs over a simple memory read port.
- Writes the resulting tag/payload into the tag RAM refill port with a one-cycle write pulse, or reports a page fault.

---
 rtl/page_walker_if.sv | 49 ++++
 rtl/page_walker.sv | 225 ++++++++++++++++++++++
 tb/tb_page_walker.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/page_walker_if.sv
// page_walker_if: signal bundle between the page-table walker and its neighbours.
//   Request side : root_ppn, req_valid, req_ready, req_vpn, flush
//   Memory side  : mem_req_valid/ready/addr, mem_resp_valid/data
//   Refill side  : refill_we, refill_idx, refill_tag, refill_payload
//   Fault report : fault, fault_level
// Modports:
//   master - the walker itself (drives req_ready, memory requests, refill and fault)
//   slave  - the environment (requester, PTE memory, tag RAM)
interface page_walker_if #(
  parameter int unsigned TAG_RAM_ADDR_WIDTH = 6,
  parameter int unsigned TAG_WIDTH          = 20,
  parameter int unsigned PAYLOAD_WIDTH      = 32
);
  logic [19:0]                   root_ppn;
  logic                          req_valid;
  logic                          req_ready;
  logic [TAG_WIDTH-1:0]          req_vpn;
  logic                          flush;

  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic [31:0]                   mem_req_addr;
  logic                          mem_resp_valid;
  logic [31:0]                   mem_resp_data;

  logic                          refill_we;
  logic [TAG_RAM_ADDR_WIDTH-1:0] refill_idx;
  logic [TAG_WIDTH-1:0]          refill_tag;
  logic [PAYLOAD_WIDTH-1:0]      refill_payload;

  logic                          fault;
  logic                          fault_level;

  modport master (
    input  root_ppn, req_valid, req_vpn, flush,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, mem_req_valid, mem_req_addr,
    output refill_we, refill_idx, refill_tag, refill_payload,
    output fault, fault_level
  );

  modport slave (
    output root_ppn, req_valid, req_vpn, flush,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, mem_req_valid, mem_req_addr,
    input  refill_we, refill_idx, refill_tag, refill_payload,
    input  fault, fault_level
  );
endinterface

// File: rtl/page_walker.sv
// page_walker: two-level (Sv32-style) hardware page-table walker feeding the MMU tag RAM refill
// port. A translation miss (VPN) is accepted in IDLE, one or two PTEs are read over a simple
// valid/ready request + single-response memory port, and the result is written to the tag RAM
// with a one-cycle refill_we pulse, or a one-cycle fault pulse is raised.
//
// Ports:
//   clk    - clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - page_walker_if.master (request, PTE memory, refill and fault signals)
//
// Parameters:
//   TAG_RAM_ADDR_WIDTH - refill index width (index = low VPN bits)
//   TAG_WIDTH          - VPN / tag width, must be 20
//   PAYLOAD_WIDTH      - refill payload width, must be 32 ({PPN, 2'b00, pte[9:0]})
//   TIMEOUT_CYCLES     - memory-response watchdog limit
//
// Build option:
//   PTW_TIMEOUT_EN - when defined, a watchdog aborts a walk (fault) or a drain (silently) after
//                    TIMEOUT_CYCLES cycles without a response. Undefined: wait indefinitely.
module page_walker #(
  parameter int unsigned TAG_RAM_ADDR_WIDTH = 6,
  parameter int unsigned TAG_WIDTH          = 20,
  parameter int unsigned PAYLOAD_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input logic           clk,
  input logic           resetn,
  page_walker_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StL1Req,
    StL1Wait,
    StL0Req,
    StL0Wait,
    StRefill,
    StFault,
    StDrain
  } state_e;

  state_e                        state_q;
  logic [TAG_WIDTH-1:0]          vpn_q;
  // Root PPN during level 1, next-level table PPN during level 0.
  logic [19:0]                   ppn_q;

  logic                          refill_we_q;
  logic [TAG_RAM_ADDR_WIDTH-1:0] refill_idx_q;
  logic [TAG_WIDTH-1:0]          refill_tag_q;
  logic [PAYLOAD_WIDTH-1:0]      refill_payload_q;
  logic                          fault_q;
  logic                          fault_level_q;

  // PTE decode of the response currently on the bus.
  logic [31:0] pte;
  logic        pte_bad;
  logic        pte_leaf;
  logic        pte_misaligned;
  logic [19:0] super_ppn;
  logic [31:0] l1_addr;
  logic [31:0] l0_addr;
  logic        tmo_hit;
  logic        unused_pte;

  assign pte            = bus.mem_resp_data;
  // Invalid, or write-only (reserved encoding).
  assign pte_bad        = !pte[0] || (!pte[1] && pte[2]);
  assign pte_leaf       = pte[1] || pte[3];
  assign pte_misaligned = (pte[19:10] != 10'h000);
  // Superpage: upper PPN from the PTE, low PPN bits come straight from VPN0.
  assign super_ppn      = {pte[29:20], vpn_q[9:0]};
  assign unused_pte     = ^pte[31:30];

  // Address arithmetic is plain 32-bit and wraps.
  assign l1_addr = {ppn_q, 12'h000} + {20'h00000, vpn_q[19:10], 2'b00};
  assign l0_addr = {ppn_q, 12'h000} + {20'h00000, vpn_q[9:0], 2'b00};

  assign bus.req_ready      = (state_q == StIdle);
  assign bus.mem_req_valid  = (state_q == StL1Req) || (state_q == StL0Req);
  assign bus.mem_req_addr   = (state_q == StL1Req) ? l1_addr :
                              (state_q == StL0Req) ? l0_addr : 32'h0000_0000;
  assign bus.refill_we      = refill_we_q;
  assign bus.refill_idx     = refill_idx_q;
  assign bus.refill_tag     = refill_tag_q;
  assign bus.refill_payload = refill_payload_q;
  assign bus.fault          = fault_q;
  assign bus.fault_level    = fault_level_q;

`ifdef PTW_TIMEOUT_EN
  localparam int unsigned TmoLog = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TmoW   = (TmoLog < 8) ? 8 : ((TmoLog > 32) ? 32 : TmoLog);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            waiting;

  assign waiting = (state_q == StL1Wait) || (state_q == StL0Wait) || (state_q == StDrain);
  // Hit on the last idle cycle so the abort takes effect exactly TIMEOUT_CYCLES cycles in.
  assign tmo_hit = waiting && !bus.mem_resp_valid &&
                   (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Counting only while waiting clears it on every WAIT/DRAIN entry; a flush out of a WAIT
  // state clears it too so DRAIN gets a full budget.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
    end else if (waiting && !bus.mem_resp_valid && !(bus.flush && (state_q != StDrain))) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= StIdle;
      vpn_q            <= '0;
      ppn_q            <= '0;
      refill_we_q      <= 1'b0;
      refill_idx_q     <= '0;
      refill_tag_q     <= '0;
      refill_payload_q <= '0;
      fault_q          <= 1'b0;
      fault_level_q    <= 1'b0;
    end else begin
      // Pulses last exactly one cycle.
      refill_we_q <= 1'b0;
      fault_q     <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.req_valid && !bus.flush) begin
            vpn_q   <= bus.req_vpn;
            ppn_q   <= bus.root_ppn;
            state_q <= StL1Req;
          end
        end

        StL1Req: begin
          if (bus.mem_req_ready) begin
            // The request is already issued, so a flush must still swallow its response.
            state_q <= bus.flush ? StDrain : StL1Wait;
          end else if (bus.flush) begin
            state_q <= StIdle;
          end
        end

        StL1Wait: begin
          if (bus.flush) begin
            // A response arriving with the flush is the outstanding one: nothing left to drain.
            state_q <= bus.mem_resp_valid ? StIdle : StDrain;
          end else if (bus.mem_resp_valid) begin
            if (pte_bad || (pte_leaf && pte_misaligned)) begin
              fault_q       <= 1'b1;
              fault_level_q <= 1'b1;
              state_q       <= StFault;
            end else if (pte_leaf) begin
              refill_we_q      <= 1'b1;
              refill_idx_q     <= vpn_q[TAG_RAM_ADDR_WIDTH-1:0];
              refill_tag_q     <= vpn_q;
              refill_payload_q <= {super_ppn, 2'b00, pte[9:0]};
              state_q          <= StRefill;
            end else begin
              ppn_q   <= pte[29:10];
              state_q <= StL0Req;
            end
          end else if (tmo_hit) begin
            fault_q       <= 1'b1;
            fault_level_q <= 1'b1;
            state_q       <= StFault;
          end
        end

        StL0Req: begin
          if (bus.mem_req_ready) begin
            state_q <= bus.flush ? StDrain : StL0Wait;
          end else if (bus.flush) begin
            state_q <= StIdle;
          end
        end

        StL0Wait: begin
          if (bus.flush) begin
            state_q <= bus.mem_resp_valid ? StIdle : StDrain;
          end else if (bus.mem_resp_valid) begin
            // No third level: a pointer here is a fault as well.
            if (pte_bad || !pte_leaf) begin
              fault_q       <= 1'b1;
              fault_level_q <= 1'b0;
              state_q       <= StFault;
            end else begin
              refill_we_q      <= 1'b1;
              refill_idx_q     <= vpn_q[TAG_RAM_ADDR_WIDTH-1:0];
              refill_tag_q     <= vpn_q;
              refill_payload_q <= {pte[29:10], 2'b00, pte[9:0]};
              state_q          <= StRefill;
            end
          end else if (tmo_hit) begin
            fault_q       <= 1'b1;
            fault_level_q <= 1'b0;
            state_q       <= StFault;
          end
        end

        StRefill: state_q <= StIdle;

        StFault: state_q <= StIdle;

        StDrain: begin
          if (bus.mem_resp_valid || tmo_hit) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_page_walker.sv
module tb_page_walker;
  localparam int unsigned AW = 6;
  localparam int unsigned TW = 20;
  localparam int unsigned PW = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  page_walker_if #(.TAG_RAM_ADDR_WIDTH(AW), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)) bus ();

  page_walker #(
    .TAG_RAM_ADDR_WIDTH(AW),
    .TAG_WIDTH         (TW),
    .PAYLOAD_WIDTH     (PW),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;
  int refill_cnt = 0;
  int fault_cnt = 0;
  int req_cnt = 0;
  int r0, f0, q0, n;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_req_valid && bus.mem_req_ready) req_cnt <= req_cnt + 1;
  end

  always @(negedge clk) begin
    if (bus.refill_we) refill_cnt <= refill_cnt + 1;
    if (bus.fault) fault_cnt <= fault_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [19:0] vpn, input logic [19:0] root);
    bus.req_valid = 1'b1;
    bus.req_vpn   = vpn;
    bus.root_ppn  = root;
    step();
    bus.req_valid = 1'b0;
    t_acc = cyc;
  endtask

  // Wait (bounded) for a request, check its address, accept it, return pte one cycle later.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] pte);
    int k = 0;
    while (!(bus.mem_req_valid && bus.mem_req_ready) && k < 50) begin
      step();
      k++;
    end
    chk({tag, "_req_valid"}, {31'b0, bus.mem_req_valid}, 32'd1);
    chk({tag, "_addr"}, bus.mem_req_addr, exp_addr);
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = pte;
    step();
    bus.mem_resp_valid = 1'b0;
  endtask

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_vpn        = '0;
    bus.root_ppn       = '0;
    bus.flush          = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;

    // Reset values
    step();
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_mem_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    chk("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
    chk("rst_refill_we", {31'b0, bus.refill_we}, 32'd0);
    chk("rst_fault", {31'b0, bus.fault}, 32'd0);
    chk("rst_payload", bus.refill_payload, 32'h0);
    resetn = 1'b1;
    step();

    // Two-level walk: VPN1=0x048, VPN0=0x345
    r0 = refill_cnt;
    issue(20'h12345, 20'h00010);
    serve("t1_l1", 32'h0001_0120, 32'h0002_0001);
    serve("t1_l0", 32'h0008_0D14, 32'h0ABC_D00F);
    chk("t1_refill_we", {31'b0, bus.refill_we}, 32'd1);
    chk("t1_latency", cyc - t_acc, 32'd4);
    chk("t1_idx", {26'b0, bus.refill_idx}, 32'h05);
    chk("t1_tag", {12'b0, bus.refill_tag}, 32'h12345);
    chk("t1_payload", bus.refill_payload, 32'h2AF3_400F);
    chk("t1_fault", {31'b0, bus.fault}, 32'd0);
    step();
    chk("t1_pulse_end", {31'b0, bus.refill_we}, 32'd0);
    chk("t1_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("t1_payload_hold", bus.refill_payload, 32'h2AF3_400F);
    chk("t1_one_refill", refill_cnt - r0, 32'd1);

    // Superpage: PPN = {0x140, 0x345} = 0x50345
    q0 = req_cnt;
    issue(20'h12345, 20'h00010);
    serve("t2", 32'h0001_0120, 32'h1400_000F);
    chk("t2_refill_we", {31'b0, bus.refill_we}, 32'd1);
    chk("t2_latency", cyc - t_acc, 32'd2);
    chk("t2_payload", bus.refill_payload, 32'h5034_500F);
    chk("t2_single_read", req_cnt - q0, 32'd1);
    step();
    chk("t2_no_more_req", {31'b0, bus.mem_req_valid}, 32'd0);

    // Invalid L1 PTE
    r0 = refill_cnt;
    issue(20'h12345, 20'h00010);
    serve("t3", 32'h0001_0120, 32'h0000_0000);
    chk("t3_fault", {31'b0, bus.fault}, 32'd1);
    chk("t3_level", {31'b0, bus.fault_level}, 32'd1);
    chk("t3_no_refill", {31'b0, bus.refill_we}, 32'd0);
    step();
    chk("t3_fault_end", {31'b0, bus.fault}, 32'd0);

    // Write-without-read at L0
    issue(20'h12345, 20'h00010);
    serve("t4_l1", 32'h0001_0120, 32'h0002_0001);
    serve("t4_l0", 32'h0008_0D14, 32'h0000_0005);
    chk("t4_fault", {31'b0, bus.fault}, 32'd1);
    chk("t4_level", {31'b0, bus.fault_level}, 32'd0);
    step();

    // Pointer at L0 (no third level)
    issue(20'h12345, 20'h00010);
    serve("t4b_l1", 32'h0001_0120, 32'h0002_0001);
    serve("t4b_l0", 32'h0008_0D14, 32'h0000_0001);
    chk("t4b_fault", {31'b0, bus.fault}, 32'd1);
    chk("t4b_level", {31'b0, bus.fault_level}, 32'd0);
    step();

    // Misaligned superpage
    issue(20'h12345, 20'h00010);
    serve("t5", 32'h0001_0120, 32'h0000_0403);
    chk("t5_fault", {31'b0, bus.fault}, 32'd1);
    chk("t5_level", {31'b0, bus.fault_level}, 32'd1);
    chk("t5_no_refill_total", refill_cnt - r0, 32'd0);
    step();

    // Address at top of the space
    issue(20'hFFC00, 20'hFFFFF);
    serve("t6", 32'hFFFF_FFFC, 32'h0000_000B);
    chk("t6_refill_we", {31'b0, bus.refill_we}, 32'd1);
    chk("t6_idx", {26'b0, bus.refill_idx}, 32'h00);
    chk("t6_tag", {12'b0, bus.refill_tag}, 32'hFFC00);
    chk("t6_payload", bus.refill_payload, 32'h0000_000B);
    step();

    // Backpressure: ready low for three cycles
    q0 = req_cnt;
    bus.mem_req_ready = 1'b0;
    issue(20'h00401, 20'h00123);
    for (int i = 0; i < 3; i++) begin
      chk("t7_hold_valid", {31'b0, bus.mem_req_valid}, 32'd1);
      chk("t7_hold_addr", bus.mem_req_addr, 32'h0012_3004);
      step();
    end
    bus.mem_req_ready = 1'b1;
    serve("t7", 32'h0012_3004, 32'h0000_000F);
    chk("t7_refill_we", {31'b0, bus.refill_we}, 32'd1);
    chk("t7_payload", bus.refill_payload, 32'h0000_100F);
    chk("t7_one_req", req_cnt - q0, 32'd1);
    step();

    // Flush in L1_WAIT: response is drained, no refill
    r0 = refill_cnt;
    f0 = fault_cnt;
    issue(20'h12345, 20'h00010);
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t8_draining", {31'b0, bus.req_ready}, 32'd0);
    step();
    chk("t8_still_draining", {31'b0, bus.req_ready}, 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h1400_000F;
    step();
    bus.mem_resp_valid = 1'b0;
    chk("t8_req_ready", {31'b0, bus.req_ready}, 32'd1);
    step();
    chk("t8_no_refill", refill_cnt - r0, 32'd0);
    chk("t8_no_fault", fault_cnt - f0, 32'd0);

    // Flush in L1_REQ before the handshake
    q0 = req_cnt;
    bus.mem_req_ready = 1'b0;
    issue(20'h12345, 20'h00010);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.mem_req_ready = 1'b1;
    chk("t9_idle", {31'b0, bus.req_ready}, 32'd1);
    chk("t9_no_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    step();
    chk("t9_no_req", req_cnt - q0, 32'd0);

    // Flush in IDLE blocks acceptance
    bus.req_valid = 1'b1;
    bus.flush     = 1'b1;
    step();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    chk("t10_not_accepted", {31'b0, bus.mem_req_valid}, 32'd0);
    chk("t10_req_ready", {31'b0, bus.req_ready}, 32'd1);

    // Reset in L0_WAIT, then a stray response
    r0 = refill_cnt;
    issue(20'h12345, 20'h00010);
    serve("t11_l1", 32'h0001_0120, 32'h0002_0001);
    step();
    #2;
    resetn = 1'b0;
    #1;
    chk("t11_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("t11_rst_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    chk("t11_rst_payload", bus.refill_payload, 32'h0);
    chk("t11_rst_tag", {12'b0, bus.refill_tag}, 32'h0);
    #1;
    resetn = 1'b1;
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0ABC_D00F;
    step();
    bus.mem_resp_valid = 1'b0;
    chk("t11_stray_refill", {31'b0, bus.refill_we}, 32'd0);
    chk("t11_stray_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    chk("t11_stray_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("t11_stray_fault", {31'b0, bus.fault}, 32'd0);
    step();
    chk("t11_no_refill", refill_cnt - r0, 32'd0);

    // Missing response
    f0 = fault_cnt;
    r0 = refill_cnt;
    issue(20'h12345, 20'h00010);
    step();
`ifdef PTW_TIMEOUT_EN
    n = 0;
    while (!bus.fault && n < 40) begin
      step();
      n++;
    end
    chk("t12_timeout_cycles", n, 32'd16);
    chk("t12_timeout_level", {31'b0, bus.fault_level}, 32'd1);
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h1400_000F;
    step();
    bus.mem_resp_valid = 1'b0;
    chk("t12_late_ignored", refill_cnt - r0, 32'd0);
    chk("t12_idle", {31'b0, bus.req_ready}, 32'd1);
`else
    repeat (1000) step();
    chk("t12_no_fault", fault_cnt - f0, 32'd0);
    chk("t12_still_waiting", {31'b0, bus.req_ready}, 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h1400_000F;
    step();
    bus.mem_resp_valid = 1'b0;
    chk("t12_late_refill", {31'b0, bus.refill_we}, 32'd1);
`endif
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
